arm_mem_mfc: RTL and testbench

//  Synthesizable byte-addressed main memory for ARM_CU_ALU; sits directly downstream of the CPU's

---
 rtl/arm_mem_mfc.sv | 146 ++++++++++++++
 tb/tb_arm_mem_mfc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_mem_mfc.sv
// Byte-addressed big-endian main memory answering the CPU MFA/MFC handshake, with an idle-time side-load port.
// Latency: MEMLOAD LATENCY+1 cycles after MFA is captured; MFC follows one cycle later and holds until MFA drops.
// Backpressure: CPU holds MFA until MFC; LD_EN is dropped unless the FSM is IDLE.
module arm_mem_mfc #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              READ_WRITE,
    input  logic              WORD_BYTE,
    input  logic [ADDR_W-1:0] MEMADD,
    input  logic [31:0]       DATA_IN,
    input  logic              LD_EN,
    input  logic [ADDR_W-1:0] LD_ADD,
    input  logic [31:0]       LD_DAT,
    output logic [31:0]       MEMDAT,
    output logic              MEMLOAD,
    output logic              MFC,
    output logic              BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              rw_q, wb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic              mfa_prev, pend, pend_nx;
    logic              capture, ld_go, wr_go, rd_go, mfc_nx;
    logic [31:0]       rd_data;

    // Word accesses ignore the low address bits; byte reads are zero-extended.
    always_comb begin
        if (wb_q)
            rd_data = {mem[{addr_q[ADDR_W-1:2], 2'd0}], mem[{addr_q[ADDR_W-1:2], 2'd1}],
                       mem[{addr_q[ADDR_W-1:2], 2'd2}], mem[{addr_q[ADDR_W-1:2], 2'd3}]};
        else
            rd_data = {24'd0, mem[addr_q]};
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = 1'b0;
        capture  = 1'b0;
        ld_go    = 1'b0;
        wr_go    = 1'b0;
        rd_go    = 1'b0;
        mfc_nx   = 1'b0;
        unique case (state)
            S_IDLE: begin
                // A side-load steals the cycle; an MFA rise seen alongside it stays pending one cycle.
                if (LD_EN) begin
                    ld_go   = 1'b1;
                    pend_nx = MFA && !mfa_prev;
                end else if (MFA && (!mfa_prev || pend)) begin
                    capture  = 1'b1;
                    cnt_nx   = LAT_M1;
                    state_nx = (LATENCY == 0) ? S_XFER : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MFA)
                    state_nx = S_IDLE;
                else if (cnt == 4'd0)
                    state_nx = S_XFER;
                else
                    cnt_nx = cnt - 4'd1;
            end
            S_XFER: begin
                wr_go = !rw_q;
                if (!MFA) begin
                    state_nx = S_IDLE;
                end else begin
                    rd_go    = rw_q;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (!MFA)
                    state_nx = S_IDLE;
                else
                    mfc_nx = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            rw_q     <= 1'b0;
            wb_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= 32'd0;
            mfa_prev <= 1'b0;
            pend     <= 1'b0;
            MEMDAT   <= 32'd0;
            MEMLOAD  <= 1'b0;
            MFC      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            mfa_prev <= MFA;
            pend     <= pend_nx;
            MEMLOAD  <= rd_go;
            MFC      <= mfc_nx;
            if (rd_go)
                MEMDAT <= rd_data;
            if (capture) begin
                rw_q   <= READ_WRITE;
                wb_q   <= WORD_BYTE;
                addr_q <= MEMADD;
                din_q  <= DATA_IN;
            end
        end
    end

    // Storage is never cleared; Reset only blocks a write in flight.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (ld_go) begin
                for (int i = 0; i < 4; i++)
                    mem[{LD_ADD[ADDR_W-1:2], 2'(i)}] <= LD_DAT[31-8*i -: 8];
            end else if (wr_go) begin
                if (wb_q) begin
                    for (int i = 0; i < 4; i++)
                        mem[{addr_q[ADDR_W-1:2], 2'(i)}] <= din_q[31-8*i -: 8];
                end else begin
                    mem[addr_q] <= din_q[7:0];
                end
            end
        end
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_arm_mem_mfc.sv
// Directed bench for arm_mem_mfc: LATENCY=2 instance checked through a read scoreboard,
// LATENCY=0 instance checked for first-cycle timing.
module tb_arm_mem_mfc;
    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset, MFA, MFA0, READ_WRITE, WORD_BYTE, LD_EN;
    logic [7:0]  MEMADD, LD_ADD;
    logic [31:0] DATA_IN, LD_DAT;
    logic [31:0] memdat, memdat0;
    logic        memload, mfc, busy, memload0, mfc0, busy0;

    always #5 Clk = ~Clk;

    arm_mem_mfc #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .READ_WRITE(READ_WRITE), .WORD_BYTE(WORD_BYTE),
        .MEMADD(MEMADD), .DATA_IN(DATA_IN), .LD_EN(LD_EN), .LD_ADD(LD_ADD), .LD_DAT(LD_DAT),
        .MEMDAT(memdat), .MEMLOAD(memload), .MFC(mfc), .BUSY(busy)
    );

    arm_mem_mfc #(.ADDR_W(8), .LATENCY(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .MFA(MFA0), .READ_WRITE(READ_WRITE), .WORD_BYTE(WORD_BYTE),
        .MEMADD(MEMADD), .DATA_IN(DATA_IN), .LD_EN(LD_EN), .LD_ADD(LD_ADD), .LD_DAT(LD_DAT),
        .MEMDAT(memdat0), .MEMLOAD(memload0), .MFC(mfc0), .BUSY(busy0)
    );

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          load_cnt = 0;
    int          last_load_cyc = -1;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'd0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every MEMLOAD strobe consumes one expected read value.
    always @(negedge Clk) begin
        if (memload === 1'b1) begin
            load_cnt++;
            last_load_cyc = cyc;
            if (exp_q.size() == 0)
                check("unexpected_load", {31'd0, memload}, 32'd0);
            else
                check("rd_data", memdat, exp_q.pop_front());
        end
    end

    task automatic side_load(input logic [7:0] a, input logic [31:0] d);
        @(negedge Clk);
        LD_EN = 1'b1; LD_ADD = a; LD_DAT = d;
        @(negedge Clk);
        LD_EN = 1'b0;
    endtask

    // One full handshake on the LATENCY=2 instance with timing checks.
    task automatic access(input bit rw, input bit wb, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input bit with_ld, input bit busy_ld,
                          input logic [31:0] ldd);
        int n, lc0, mfc_cyc;
        bit seen;
        @(negedge Clk);
        READ_WRITE = rw; WORD_BYTE = wb; MEMADD = a; DATA_IN = d; MFA = 1'b1;
        n = cyc + 1;
        if (with_ld) begin
            LD_EN = 1'b1; LD_ADD = a; LD_DAT = ldd;
            n = cyc + 2;
        end
        lc0 = load_cnt;
        if (rw) begin
            exp_q.push_back(exp);
            last_rd = exp;
        end
        seen = 1'b0;
        mfc_cyc = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge Clk);
            if (k == 0) begin
                if (with_ld) LD_EN = 1'b0;
                if (busy_ld) begin
                    LD_EN = 1'b1; LD_ADD = a; LD_DAT = ldd;
                end
            end
            if (k == 1 && busy_ld) LD_EN = 1'b0;
            if (mfc === 1'b1) begin
                seen = 1'b1;
                mfc_cyc = cyc;
            end
        end
        check("mfc_cycle", 32'(mfc_cyc), 32'(n + 2 + LAT));
        check("load_count", 32'(load_cnt - lc0), rw ? 32'd1 : 32'd0);
        if (rw) check("load_cycle", 32'(last_load_cyc), 32'(n + 1 + LAT));
        MFA = 1'b0;
        @(negedge Clk);
        check("mfc_drop", {31'd0, mfc}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lc0, n, ld_c, mf_c;
        bit mfc_any;
        logic [31:0] d0;

        Reset = 1'b1; MFA = 1'b0; MFA0 = 1'b0; READ_WRITE = 1'b0; WORD_BYTE = 1'b0;
        MEMADD = 8'd0; DATA_IN = 32'd0; LD_EN = 1'b0; LD_ADD = 8'd0; LD_DAT = 32'd0;
        repeat (3) @(negedge Clk);
        check("rst_memdat", memdat, 32'd0);
        check("rst_memload", {31'd0, memload}, 32'd0);
        check("rst_mfc", {31'd0, mfc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_memdat0", memdat0, 32'd0);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        Reset = 1'b0;

        // Reset held three cycles in the middle of a write's WAIT.
        side_load(8'h10, 32'h11223344);
        @(negedge Clk);
        READ_WRITE = 1'b0; WORD_BYTE = 1'b1; MEMADD = 8'h10; DATA_IN = 32'hDEADBEEF; MFA = 1'b1;
        @(negedge Clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_mfc", {31'd0, mfc}, 32'd0);
        check("mid_rst_memload", {31'd0, memload}, 32'd0);
        check("mid_rst_memdat", memdat, 32'd0);
        MFA = 1'b0; Reset = 1'b0;
        access(1, 1, 8'h10, 32'd0, 32'h11223344, 0, 0, 32'd0);

        // Side-loaded program image, word reads (LD_ADD low bits ignored).
        side_load(8'h00, 32'hE2010000);
        side_load(8'h06, 32'hE3801028);
        access(1, 1, 8'h04, 32'd0, 32'hE3801028, 0, 0, 32'd0);
        access(1, 1, 8'h00, 32'd0, 32'hE2010000, 0, 0, 32'd0);

        // Byte write touches only its own lane; MEMDAT keeps the last read value.
        access(0, 0, 8'h05, 32'h123456AB, 32'd0, 0, 0, 32'd0);
        check("memdat_hold", memdat, last_rd);
        access(1, 1, 8'h04, 32'd0, 32'hE3AB1028, 0, 0, 32'd0);
        access(1, 0, 8'h05, 32'd0, 32'h000000AB, 0, 0, 32'd0);
        access(1, 0, 8'h04, 32'd0, 32'h000000E3, 0, 0, 32'd0);
        access(1, 1, 8'h07, 32'd0, 32'hE3AB1028, 0, 0, 32'd0);

        // Word write is big-endian.
        access(0, 1, 8'h0C, 32'h01020304, 32'd0, 0, 0, 32'd0);
        access(1, 0, 8'h0E, 32'd0, 32'h00000003, 0, 0, 32'd0);
        access(1, 1, 8'h0D, 32'd0, 32'h01020304, 0, 0, 32'd0);

        // LATENCY=0 instance: it only saw the side-loads, so 0x04 holds the original word.
        @(negedge Clk);
        READ_WRITE = 1'b1; WORD_BYTE = 1'b1; MEMADD = 8'h06; MFA0 = 1'b1;
        n = cyc + 1; ld_c = -1; mf_c = -1; d0 = 32'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (memload0 === 1'b1 && ld_c < 0) begin
                ld_c = cyc;
                d0 = memdat0;
            end
            if (mfc0 === 1'b1 && mf_c < 0) mf_c = cyc;
        end
        check("lat0_load_cycle", 32'(ld_c), 32'(n + 1));
        check("lat0_data", d0, 32'hE3801028);
        check("lat0_mfc_cycle", 32'(mf_c), 32'(n + 2));
        MFA0 = 1'b0;
        @(negedge Clk);
        check("lat0_busy_idle", {31'd0, busy0}, 32'd0);

        // MFA dropped during WAIT of a write: nothing performed.
        side_load(8'h08, 32'hCAFEF00D);
        @(negedge Clk);
        READ_WRITE = 1'b0; WORD_BYTE = 1'b1; MEMADD = 8'h08; DATA_IN = 32'h0BADBAD0; MFA = 1'b1;
        lc0 = load_cnt;
        @(negedge Clk);
        check("abort_busy", {31'd0, busy}, 32'd1);
        MFA = 1'b0;
        @(negedge Clk);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        mfc_any = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            mfc_any = mfc_any | mfc;
        end
        check("abort_no_mfc", {31'd0, mfc_any}, 32'd0);
        check("abort_no_load", 32'(load_cnt - lc0), 32'd0);
        access(1, 1, 8'h08, 32'd0, 32'hCAFEF00D, 0, 0, 32'd0);

        // Side-load and MFA rise together; then a side-load while busy is dropped.
        access(1, 1, 8'h20, 32'd0, 32'h5A5AA5A5, 1, 0, 32'h5A5AA5A5);
        access(1, 1, 8'h20, 32'd0, 32'h5A5AA5A5, 0, 1, 32'hFFFFFFFF);
        access(1, 1, 8'h22, 32'd0, 32'h5A5AA5A5, 0, 0, 32'd0);

        repeat (2) @(negedge Clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
